mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 124 ++++++++++++
 tb/tb_mem_io_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// CPU-facing RAM plus memory-mapped IO: UART receive/transmit, a free-running cycle counter
// with byte snapshot, and a sticky program-stop flag.
module mem_io_responder #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned TXQ_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int unsigned PtrW = $clog2(TXQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]  ram [2**ADDR_W];
  logic [7:0]  txq_mem [TXQ_DEPTH];

  logic [7:0]      rdata_q, rdata_d;
  logic [31:0]     cyc_q, snap_q, snap_d;
  logic            stop_q, ovf_q;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [17:0]       a18;
  logic [ADDR_W-1:0] ram_idx;
  logic              is_io, io_rx, io_ctr, io_snap;
  logic              push, pop, full, accept;
  logic [7:0]        push_data;
  logic              unused_a;

  assign unused_a = ^mem_a[31:18];
  assign a18      = mem_a[17:0];
  assign ram_idx  = mem_a[ADDR_W-1:0];
  assign is_io    = (a18[17:16] == 2'b11);
  assign io_rx    = (a18 == 18'h30000);
  assign io_ctr   = (a18 == 18'h30004);
  // 0x30004..0x30007 share one word-aligned slot
  assign io_snap  = (a18[17:2] == 16'hC001);

  assign push      = mem_wr && is_io && ((io_rx && (mem_dout != 8'h00)) || io_ctr);
  assign push_data = io_rx ? mem_dout : 8'h00;
  assign pop       = tx_valid && tx_ready;
  assign full      = (cnt_q == CntW'(TXQ_DEPTH));
  assign accept    = push && (!full || pop);

  assign tx_valid     = (cnt_q != '0);
  assign tx_data      = txq_mem[rptr_q];
  assign rdy_out      = (cnt_q < CntW'(TXQ_DEPTH - 1));
  assign rx_pop       = rst_in && !mem_wr && io_rx && rx_valid;
  assign mem_din      = rdata_q;
  assign program_stop = stop_q;
  assign tx_overflow  = ovf_q;

  always_comb begin
    rdata_d = 8'h00;
    snap_d  = snap_q;
    if (!mem_wr) begin
      if (!is_io) begin
        rdata_d = ram[ram_idx];
      end else if (io_rx) begin
        rdata_d = rx_valid ? rx_data : 8'h00;
      end else if (io_snap) begin
        if (a18[1:0] == 2'd0) begin
          snap_d  = cyc_q;
          rdata_d = cyc_q[7:0];
        end else begin
          rdata_d = snap_q[{a18[1:0], 3'b000} +: 8];
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (mem_wr && !is_io) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (accept) txq_mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdata_q <= 8'h00;
      cyc_q   <= '0;
      snap_q  <= '0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      if (!stop_q) cyc_q <= cyc_q + 32'd1;
      if (mem_wr && io_ctr) stop_q <= 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
      if (accept) wptr_q <= wptr_q + PtrW'(1);
      if (pop) rptr_q <= rptr_q + PtrW'(1);
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench: vector table for RAM/IO reads, scoreboards for read data and tx stream.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_stop;
  logic        tx_overflow;

  mem_io_responder #(.ADDR_W(17), .TXQ_DEPTH(8)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .mem_a        (mem_a),
    .mem_wr       (mem_wr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din),
    .rdy_out      (rdy_out),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_pop       (rx_pop),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .program_stop (program_stop),
    .tx_overflow  (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        chk;
    logic [7:0]  exp;
    logic        pop;
  } vec_t;

  typedef struct {
    logic       chk;
    logic [7:0] exp;
    string      nm;
  } rd_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  rd_t  rd_q[$];
  logic [7:0] tx_exp[$];

  // Reference cycle counter: counts edges out of reset until a stop write is seen.
  logic [31:0] cnt_m;
  logic        stop_m;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_m  <= 32'd0;
      stop_m <= 1'b0;
    end else begin
      if (!stop_m) cnt_m <= cnt_m + 32'd1;
      if (mem_wr && mem_a[17:0] == 18'h30004) stop_m <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Transfers are sampled mid-cycle, where inputs are stable before the accepting edge.
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) begin
      checks++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %h, required no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = tx_exp.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_stream: got %h, required %h", tx_data, e);
        end
      end
    end
  end

  task automatic set_idle();
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic rxv, input logic [7:0] rxd, input logic c,
                        input logic [7:0] exp, input logic exp_pop, input string nm);
    rd_t r;
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    rx_valid = rxv;
    rx_data  = rxd;
    rd_q.push_back('{c, exp, nm});
    #1;
    chk({nm, "_rx_pop"}, {31'd0, rx_pop}, {31'd0, exp_pop});
    @(posedge clk_in);
    #1;
    r = rd_q.pop_front();
    if (r.chk) chk(r.nm, {24'd0, mem_din}, {24'd0, r.exp});
    set_idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string nm);
    access(a, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, exp, 1'b0, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input string nm);
    access(a, 1'b1, d, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (tx_exp.size() == 0 && !tx_valid) break;
      @(posedge clk_in);
      #1;
    end
    chk(nm, {31'd0, (tx_exp.size() == 0 && !tx_valid)}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    rst_in   = 1'b0;
    tx_ready = 1'b1;
    set_idle();
    #3;
    chk("rst_mem_din", {24'd0, mem_din}, 32'h0);
    chk("rst_rx_pop", {31'd0, rx_pop}, 32'h0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    chk("rst_rdy_out", {31'd0, rdy_out}, 32'h1);
    chk("rst_program_stop", {31'd0, program_stop}, 32'h0);
    chk("rst_tx_overflow", {31'd0, tx_overflow}, 32'h0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // {addr, wr, data, rx_valid, rx_data, check, expected mem_din, expected rx_pop}
    vecs.push_back('{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{32'h0000_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0});
    vecs.push_back('{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{32'hFFFC_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0});
    vecs.push_back('{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h77, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h41, 1'b1});
    vecs.push_back('{32'h0007_0000, 1'b0, 8'h00, 1'b1, 8'h52, 1'b1, 8'h52, 1'b1});
    vecs.push_back('{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{32'h0003_0008, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{32'h0003_0000, 1'b1, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].a, vecs[i].wr, vecs[i].d, vecs[i].rxv, vecs[i].rxd, vecs[i].chk,
             vecs[i].exp, vecs[i].pop, $sformatf("vec%0d", i));
    end
    idle(3);
    chk("ignored_io_write_tx_valid", {31'd0, tx_valid}, 32'h0);

    // UART out: zero byte is not queued
    tx_exp.push_back(8'h48);
    wr(32'h3_0000, 8'h48, "uart_w0");
    wr(32'h3_0000, 8'h00, "uart_w1");
    tx_exp.push_back(8'h69);
    wr(32'h3_0000, 8'h69, "uart_w2");
    wait_drain("uart_drain");
    chk("uart_overflow", {31'd0, tx_overflow}, 32'h0);

    // Backpressure with a stalled UART
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_exp.push_back(8'h11 + 8'(i));
      wr(32'h3_0000, 8'h11 + 8'(i), $sformatf("bp_push%0d", i));
      chk($sformatf("bp_rdy_after%0d", i + 1), {31'd0, rdy_out}, {31'd0, (i + 1 < 7)});
    end
    chk("bp_overflow_before", {31'd0, tx_overflow}, 32'h0);
    wr(32'h3_0000, 8'h19, "bp_push8");
    chk("bp_overflow_after", {31'd0, tx_overflow}, 32'h1);
    rd(32'h0000_0123, 8'hA5, "bp_ram_while_stalled");
    tx_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_rdy_restored", {31'd0, rdy_out}, 32'h1);
    chk("bp_overflow_sticky", {31'd0, tx_overflow}, 32'h1);

    // Counter snapshot; long idle makes byte 1 non-zero
    idle(300);
    s = cnt_m;
    rd(32'h3_0004, s[7:0],   "ctr_b0");
    rd(32'h3_0005, s[15:8],  "ctr_b1");
    rd(32'h3_0006, s[23:16], "ctr_b2");
    rd(32'h3_0007, s[31:24], "ctr_b3");
    idle(5);
    rd(32'h3_0005, s[15:8], "ctr_no_resnap");
    chk("ctr_b1_nonzero", {31'd0, (s[15:8] != 8'h00)}, 32'h1);
    s = cnt_m;
    rd(32'h3_0004, s[7:0], "ctr_resnap_b0");
    rd(32'h3_0005, s[15:8], "ctr_resnap_b1");

    // Program stop
    tx_exp.push_back(8'h00);
    wr(32'h3_0004, 8'h99, "stop_w");
    chk("stop_flag", {31'd0, program_stop}, 32'h1);
    wait_drain("stop_drain");
    s = cnt_m;
    rd(32'h3_0004, s[7:0], "stop_ctr_a");
    idle(7);
    rd(32'h3_0004, s[7:0], "stop_ctr_b");
    rd(32'h3_0005, s[15:8], "stop_ctr_b1");

    // Async reset with queued bytes and a pending read
    tx_ready = 1'b0;
    wr(32'h3_0000, 8'h31, "rst_q0");
    wr(32'h3_0000, 8'h32, "rst_q1");
    wr(32'h3_0000, 8'h33, "rst_q2");
    chk("rst_pre_tx_valid", {31'd0, tx_valid}, 32'h1);
    mem_a = 32'h0000_0123;
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_tx_valid", {31'd0, tx_valid}, 32'h0);
    chk("arst_rdy_out", {31'd0, rdy_out}, 32'h1);
    chk("arst_program_stop", {31'd0, program_stop}, 32'h0);
    chk("arst_tx_overflow", {31'd0, tx_overflow}, 32'h0);
    @(posedge clk_in);
    #1;
    chk("arst_mem_din_held", {24'd0, mem_din}, 32'h0);
    set_idle();
    rst_in = 1'b1;
    rd(32'h3_0004, 8'h00, "post_rst_ctr0");
    rd(32'h0000_0123, 8'hA5, "post_rst_ram_kept");
    rd(32'h3_0004, 8'h02, "post_rst_ctr2");
    tx_ready = 1'b1;
    idle(4);
    chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
